// File: rtl/regfile_2r1w_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard for RAW stalls.
// Define RF_BYPASS_EN for write-first forwarding; otherwise reads are read-first in a write cycle.
module regfile_2r1w_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            any_busy,
  output logic [AW:0]     busy_cnt
);

  localparam int NREGS = 2 ** AW;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      cnt_nxt;
  logic             we_eff;
  logic             rsv_eff;
  logic             rs1_zero;
  logic             rs2_zero;

  // With the hardwired zero register, anything aimed at x0 is simply dropped.
  assign we_eff   = we && !(ZERO_REG && (wr_addr == '0));
  assign rsv_eff  = rsv_en && !(ZERO_REG && (rsv_addr == '0));
  assign rs1_zero = ZERO_REG && (rs1_addr == '0);
  assign rs2_zero = ZERO_REG && (rs2_addr == '0);

  // Reservation is applied after release so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (we_eff)
      busy_nxt[wr_addr] = 1'b0;
    if (rsv_eff)
      busy_nxt[rsv_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (we_eff)
        regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign any_busy = (busy_cnt != '0);

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
`ifdef RF_BYPASS_EN
    if (we && (wr_addr == rs1_addr))
      rs1_data = wr_data;
    if (we && (wr_addr == rs2_addr))
      rs2_data = wr_data;
`endif
    if (rs1_zero)
      rs1_data = '0;
    if (rs2_zero)
      rs2_data = '0;
  end

  // A committing write hides the busy bit immediately so decode can issue this cycle.
  assign rs1_busy = !rs1_zero && busy[rs1_addr] && !(we && (wr_addr == rs1_addr));
  assign rs2_busy = !rs2_zero && busy[rs2_addr] && !(we && (wr_addr == rs2_addr));

endmodule
